// File: rtl/pipeline_dbg_pkg.sv
// Shared types for the pipeline execution/debug controller: command codes, FSM states
// and the dump-stream layout (registers, memory window, PC, optional cycle count).
package pipeline_dbg_pkg;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_STEP  = 2'b01,
    CMD_DUMP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_HALTED,
    ST_DUMP_ADDR,
    ST_DUMP_WAIT,
    ST_DUMP_OUT
  } state_e;

  // Dump word index layout: [0, reg_words) registers, [reg_words, mem_end) memory,
  // mem_end is the PC word, mem_end+1 the cycle count when present.
  function automatic int reg_words(input int reg_sz);
    return 1 << reg_sz;
  endfunction

  function automatic int mem_end(input int reg_sz, input int mem_words);
    return reg_words(reg_sz) + mem_words;
  endfunction

  function automatic int dump_words(input int reg_sz, input int mem_words, input bit cnt_en);
    return mem_end(reg_sz, mem_words) + 1 + (cnt_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/pipeline_exec_ctrl_dump_sequencer.sv
// Dump stream engine: word index, segment select, debug read addresses and the
// valid/ready output register. Capture is triggered by the parent FSM's wait state.
module dump_sequencer
  import pipeline_dbg_pkg::*;
#(
  parameter int PC_SZ          = 32,
  parameter int DATA_SZ        = 32,
  parameter int REG_SZ         = 5,
  parameter int MEM_SZ         = 10,
  parameter int DUMP_MEM_WORDS = 32,
  parameter int CNT_SZ         = 32,
  parameter bit CNT_EN         = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_capture,
  input  logic [PC_SZ-1:0]   i_pc,
  input  logic [CNT_SZ-1:0]  i_cycle_cnt,
  input  logic [DATA_SZ-1:0] i_dbg_reg_data,
  input  logic [DATA_SZ-1:0] i_dbg_mem_data,
  input  logic               i_dump_ready,
  output logic [REG_SZ-1:0]  o_dbg_reg_addr,
  output logic [MEM_SZ-1:0]  o_dbg_mem_addr,
  output logic               o_dump_valid,
  output logic [DATA_SZ-1:0] o_dump_data,
  output logic               o_dump_last,
  output logic               o_word_done,
  output logic               o_dump_done
);

  localparam int N_WORDS = dump_words(REG_SZ, DUMP_MEM_WORDS, CNT_EN);
  localparam int IDX_W   = $clog2(N_WORDS);
  localparam logic [IDX_W-1:0] REG_END  = IDX_W'(reg_words(REG_SZ));
  localparam logic [IDX_W-1:0] PC_IDX   = IDX_W'(mem_end(REG_SZ, DUMP_MEM_WORDS));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  logic [IDX_W-1:0]   r_idx;
  logic               r_valid;
  logic               r_last;
  logic [DATA_SZ-1:0] r_data;

  logic               w_in_reg;
  logic               w_in_mem;
  logic [IDX_W-1:0]   w_mem_off;
  logic [DATA_SZ-1:0] w_word;
  logic               w_hs;

  always_comb begin
    w_in_reg  = (r_idx < REG_END);
    w_in_mem  = !w_in_reg && (r_idx < PC_IDX);
    w_mem_off = r_idx - REG_END;
    if (w_in_reg)            w_word = i_dbg_reg_data;
    else if (w_in_mem)       w_word = i_dbg_mem_data;
    else if (r_idx == PC_IDX) w_word = DATA_SZ'(i_pc);
    else                     w_word = DATA_SZ'(i_cycle_cnt);
  end

  // Addresses follow the index, which only moves on a handshake, so the read
  // data is settled by the capture cycle for either async or 1-cycle RAMs.
  assign o_dbg_reg_addr = w_in_reg ? REG_SZ'(r_idx) : '0;
  assign o_dbg_mem_addr = w_in_mem ? MEM_SZ'(w_mem_off) : '0;

  assign w_hs = r_valid && i_dump_ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (i_capture) begin
      r_valid <= 1'b1;
      r_last  <= (r_idx == LAST_IDX);
      r_data  <= w_word;
    end else if (w_hs) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_idx   <= r_last ? '0 : r_idx + 1'b1;
    end
  end

  assign o_dump_valid = r_valid;
  assign o_dump_data  = r_data;
  assign o_dump_last  = r_last;
  assign o_word_done  = w_hs;
  assign o_dump_done  = w_hs && r_last;

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Run/step/dump controller for the MIPS pipeline. Define PIPE_CYCLE_CNT_EN to build
// the executed-cycle counter and append it as the final dump word.
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | pipeline frozen, accepting commands
// RUN       | enabled until the halt flag reaches WB
// STEP      | single enabled cycle, then back to IDLE (or HALTED)
// HALTED    | program finished; RUN/STEP rejected
// DUMP_ADDR | debug address for current word presented
// DUMP_WAIT | read data captured into the dump register
// DUMP_OUT  | word offered on the dump port until ready
module pipeline_exec_ctrl
  import pipeline_dbg_pkg::*;
#(
  parameter int PC_SZ          = 32,
  parameter int DATA_SZ        = 32,
  parameter int REG_SZ         = 5,
  parameter int MEM_SZ         = 10,
  parameter int DUMP_MEM_WORDS = 32,
  parameter int CNT_SZ         = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd,
  output logic               o_cmd_ready,
  output logic               o_err,
  input  logic               i_halt,
  input  logic [PC_SZ-1:0]   i_pc,
  output logic               o_enable,
  output logic               o_pipe_reset,
  output logic [REG_SZ-1:0]  o_dbg_reg_addr,
  output logic [MEM_SZ-1:0]  o_dbg_mem_addr,
  input  logic [DATA_SZ-1:0] i_dbg_reg_data,
  input  logic [DATA_SZ-1:0] i_dbg_mem_data,
  output logic               o_dump_valid,
  output logic [DATA_SZ-1:0] o_dump_data,
  output logic               o_dump_last,
  input  logic               i_dump_ready,
  output logic [CNT_SZ-1:0]  o_cycle_cnt,
  output logic               o_halted
);

`ifdef PIPE_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  state_e r_state, w_state_nxt;
  logic   r_origin_halted, w_origin_nxt;
  logic   r_err, w_err_nxt;
  logic   r_pipe_reset, w_pipe_reset_nxt;
  logic   w_accept;
  cmd_e   w_cmd;
  logic   w_word_done, w_dump_done;
  logic [CNT_SZ-1:0] w_cycle_cnt;

  assign w_cmd       = cmd_e'(i_cmd);
  assign o_cmd_ready = (r_state == ST_IDLE) || (r_state == ST_HALTED);
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  // Combinational so the cycle in which halt reaches WB never advances the pipe.
  assign o_enable    = ((r_state == ST_RUN) || (r_state == ST_STEP)) && !i_halt;
  assign o_halted    = (r_state == ST_HALTED);

  always_comb begin
    w_state_nxt      = r_state;
    w_origin_nxt     = r_origin_halted;
    w_err_nxt        = 1'b0;
    w_pipe_reset_nxt = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (w_accept) begin
          case (w_cmd)
            CMD_RUN: begin
              if (r_state == ST_IDLE) w_state_nxt = ST_RUN;
              else                    w_err_nxt   = 1'b1;
            end
            CMD_STEP: begin
              if (r_state == ST_IDLE) w_state_nxt = ST_STEP;
              else                    w_err_nxt   = 1'b1;
            end
            CMD_DUMP: begin
              w_origin_nxt = (r_state == ST_HALTED);
              w_state_nxt  = ST_DUMP_ADDR;
            end
            default: begin
              w_pipe_reset_nxt = 1'b1;
              w_state_nxt      = ST_IDLE;
            end
          endcase
        end
      end
      ST_RUN:       if (i_halt) w_state_nxt = ST_HALTED;
      ST_STEP:      w_state_nxt = i_halt ? ST_HALTED : ST_IDLE;
      ST_DUMP_ADDR: w_state_nxt = ST_DUMP_WAIT;
      ST_DUMP_WAIT: w_state_nxt = ST_DUMP_OUT;
      ST_DUMP_OUT: begin
        if (w_dump_done)      w_state_nxt = r_origin_halted ? ST_HALTED : ST_IDLE;
        else if (w_word_done) w_state_nxt = ST_DUMP_ADDR;
      end
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state         <= ST_IDLE;
      r_origin_halted <= 1'b0;
      r_err           <= 1'b0;
      r_pipe_reset    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_origin_halted <= w_origin_nxt;
      r_err           <= w_err_nxt;
      r_pipe_reset    <= w_pipe_reset_nxt;
    end
  end

  assign o_err        = r_err;
  assign o_pipe_reset = r_pipe_reset;

`ifdef PIPE_CYCLE_CNT_EN
  logic [CNT_SZ-1:0] r_cycle_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cycle_cnt <= '0;
    end else if (w_accept && (w_cmd == CMD_CLEAR)) begin
      r_cycle_cnt <= '0;
    end else if (o_enable && !(&r_cycle_cnt)) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  assign w_cycle_cnt = r_cycle_cnt;
`else
  assign w_cycle_cnt = '0;
`endif

  assign o_cycle_cnt = w_cycle_cnt;

  dump_sequencer #(
    .PC_SZ         (PC_SZ),
    .DATA_SZ       (DATA_SZ),
    .REG_SZ        (REG_SZ),
    .MEM_SZ        (MEM_SZ),
    .DUMP_MEM_WORDS(DUMP_MEM_WORDS),
    .CNT_SZ        (CNT_SZ),
    .CNT_EN        (CNT_EN)
  ) u_dump_seq (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_capture     (r_state == ST_DUMP_WAIT),
    .i_pc          (i_pc),
    .i_cycle_cnt   (w_cycle_cnt),
    .i_dbg_reg_data(i_dbg_reg_data),
    .i_dbg_mem_data(i_dbg_mem_data),
    .i_dump_ready  (i_dump_ready),
    .o_dbg_reg_addr(o_dbg_reg_addr),
    .o_dbg_mem_addr(o_dbg_mem_addr),
    .o_dump_valid  (o_dump_valid),
    .o_dump_data   (o_dump_data),
    .o_dump_last   (o_dump_last),
    .o_word_done   (w_word_done),
    .o_dump_done   (w_dump_done)
  );

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed bench for pipeline_exec_ctrl: run-to-halt, stepping, error/clear,
// dumps with steady and throttled ready, and reset in the middle of a dump.
module tb_pipeline_exec_ctrl;
  localparam int PC_SZ = 32, DATA_SZ = 32, REG_SZ = 2, MEM_SZ = 10;
  localparam int DUMP_MEM_WORDS = 2, CNT_SZ = 32;
`ifdef PIPE_CYCLE_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif
  localparam int N_WORDS = 4 + 2 + 1 + CNT_EN;

  logic               i_clk, i_reset, i_cmd_valid, o_cmd_ready, o_err, i_halt;
  logic [1:0]         i_cmd;
  logic [PC_SZ-1:0]   i_pc;
  logic               o_enable, o_pipe_reset, o_dump_valid, o_dump_last, i_dump_ready, o_halted;
  logic [REG_SZ-1:0]  o_dbg_reg_addr;
  logic [MEM_SZ-1:0]  o_dbg_mem_addr;
  logic [DATA_SZ-1:0] i_dbg_reg_data, i_dbg_mem_data, o_dump_data;
  logic [CNT_SZ-1:0]  o_cycle_cnt;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] got_word[$];
  logic        got_last[$];

  pipeline_exec_ctrl #(
    .PC_SZ(PC_SZ), .DATA_SZ(DATA_SZ), .REG_SZ(REG_SZ), .MEM_SZ(MEM_SZ),
    .DUMP_MEM_WORDS(DUMP_MEM_WORDS), .CNT_SZ(CNT_SZ)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .o_err(o_err), .i_halt(i_halt), .i_pc(i_pc),
    .o_enable(o_enable), .o_pipe_reset(o_pipe_reset),
    .o_dbg_reg_addr(o_dbg_reg_addr), .o_dbg_mem_addr(o_dbg_mem_addr),
    .i_dbg_reg_data(i_dbg_reg_data), .i_dbg_mem_data(i_dbg_mem_data),
    .o_dump_valid(o_dump_valid), .o_dump_data(o_dump_data), .o_dump_last(o_dump_last),
    .i_dump_ready(i_dump_ready), .o_cycle_cnt(o_cycle_cnt), .o_halted(o_halted)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  assign i_dbg_reg_data = 32'h10 + 32'(o_dbg_reg_addr);
  assign i_dbg_mem_data = 32'h20 + 32'(o_dbg_mem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Called at a falling edge; returns at the falling edge of the cycle after acceptance.
  task automatic send(input logic [1:0] c);
    i_cmd = c;
    i_cmd_valid = 1'b1;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  function automatic logic [31:0] exp_word(input int k, input logic [31:0] cnt);
    if (k < 4)      return 32'h10 + 32'(k);
    else if (k < 6) return 32'h20 + 32'(k - 4);
    else if (k == 6) return 32'h40;
    else            return cnt;
  endfunction

  task automatic run_dump(input bit throttle, output int cyc, output bit stable_ok);
    logic pv, pr;
    logic [31:0] pd;
    got_word.delete();
    got_last.delete();
    stable_ok = 1'b1;
    pv = 1'b0; pr = 1'b0; pd = '0;
    i_dump_ready = !throttle;
    send(2'b10);
    cyc = 1;
    while (!o_cmd_ready && cyc < 400) begin
      if (throttle) i_dump_ready = (cyc % 3 == 1);
      #1;
      if (pv && !pr && !(o_dump_valid === 1'b1 && o_dump_data === pd)) stable_ok = 1'b0;
      if (o_dump_valid && i_dump_ready) begin
        got_word.push_back(o_dump_data);
        got_last.push_back(o_dump_last);
      end
      pv = o_dump_valid; pr = i_dump_ready; pd = o_dump_data;
      @(negedge i_clk);
      cyc++;
    end
    i_dump_ready = 1'b0;
  endtask

  task automatic chk_words(input string tag, input logic [31:0] cnt);
    chk({tag, "_count"}, 64'(got_word.size()), 64'(N_WORDS));
    for (int k = 0; k < N_WORDS; k++) begin
      chk($sformatf("%s_word%0d", tag, k), 64'(got_word[k]), 64'(exp_word(k, cnt)));
      chk($sformatf("%s_last%0d", tag, k), 64'(got_last[k]), 64'(k == N_WORDS - 1));
    end
  endtask

  initial begin
    int  cyc, hs;
    bit  stable;
    i_reset = 1'b0; i_cmd_valid = 1'b0; i_cmd = 2'b00; i_halt = 1'b0;
    i_pc = 32'h40; i_dump_ready = 1'b0;
    @(negedge i_clk);
    chk("rst_ready", 64'(o_cmd_ready), 64'd1);
    chk("rst_enable", 64'(o_enable), 64'd0);
    chk("rst_halted", 64'(o_halted), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_pipe_reset", 64'(o_pipe_reset), 64'd0);
    chk("rst_valid", 64'(o_dump_valid), 64'd0);
    chk("rst_last", 64'(o_dump_last), 64'd0);
    chk("rst_data", 64'(o_dump_data), 64'd0);
    chk("rst_cnt", 64'(o_cycle_cnt), 64'd0);
    chk("rst_addr", 64'({o_dbg_reg_addr, o_dbg_mem_addr}), 64'd0);
    i_reset = 1'b1;
    @(negedge i_clk);

    // Run for 20 enabled cycles, then raise halt.
    send(2'b00);
    chk("run_enable", 64'(o_enable), 64'd1);
    chk("run_busy", 64'(o_cmd_ready), 64'd0);
    repeat (20) @(negedge i_clk);
    i_halt = 1'b1;
    #1;
    chk("run_halt_enable", 64'(o_enable), 64'd0);
    @(negedge i_clk);
    chk("run_halted", 64'(o_halted), 64'd1);
    chk("run_cnt", 64'(o_cycle_cnt), 64'(CNT_EN ? 20 : 0));

    // RUN while halted is rejected.
    send(2'b00);
    chk("halt_run_err", 64'(o_err), 64'd1);
    chk("halt_run_enable", 64'(o_enable), 64'd0);
    chk("halt_run_state", 64'(o_halted), 64'd1);
    @(negedge i_clk);
    chk("halt_run_err_pulse", 64'(o_err), 64'd0);

    // CLEAR from HALTED.
    i_halt = 1'b0;
    send(2'b11);
    chk("clr_pipe_reset", 64'(o_pipe_reset), 64'd1);
    chk("clr_cnt", 64'(o_cycle_cnt), 64'd0);
    chk("clr_idle", 64'({o_halted, o_cmd_ready}), 64'b01);
    @(negedge i_clk);
    chk("clr_pulse_end", 64'(o_pipe_reset), 64'd0);

    // Three single steps.
    for (int s = 0; s < 3; s++) begin
      send(2'b01);
      chk($sformatf("step%0d_enable", s), 64'(o_enable), 64'd1);
      @(negedge i_clk);
      chk($sformatf("step%0d_off", s), 64'({o_enable, o_cmd_ready}), 64'b01);
    end
    chk("step_cnt", 64'(o_cycle_cnt), 64'(CNT_EN ? 3 : 0));

    // Step with halt already high: no enable, no count, go to HALTED.
    i_halt = 1'b1;
    send(2'b01);
    chk("step_halt_enable", 64'(o_enable), 64'd0);
    @(negedge i_clk);
    chk("step_halt_state", 64'(o_halted), 64'd1);
    chk("step_halt_cnt", 64'(o_cycle_cnt), 64'(CNT_EN ? 3 : 0));

    // Dump from HALTED, ready held high.
    run_dump(1'b0, cyc, stable);
    chk("dump1_cycles", 64'(cyc), 64'(3 * N_WORDS + 1));
    chk_words("dump1", 32'd3);
    chk("dump1_origin", 64'(o_halted), 64'd1);

    // Back to IDLE, one step, then a throttled dump.
    i_halt = 1'b0;
    send(2'b11);
    send(2'b01);
    @(negedge i_clk);
    run_dump(1'b1, cyc, stable);
    chk("dump2_stable", 64'(stable), 64'd1);
    chk_words("dump2", 32'd1);
    chk("dump2_origin", 64'({o_halted, o_cmd_ready}), 64'b01);

    // Reset while the 5th word is on the port.
    i_dump_ready = 1'b1;
    send(2'b10);
    hs = 0; cyc = 0;
    while (!(o_dump_valid && hs == 4) && cyc < 100) begin
      #1;
      if (o_dump_valid && i_dump_ready) hs++;
      @(negedge i_clk);
      cyc++;
    end
    chk("mid_word5", 64'({o_dump_valid, o_dump_data}), {31'd0, 1'b1, 32'h20});
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("mid_rst_valid", 64'({o_dump_valid, o_dump_last}), 64'd0);
    chk("mid_rst_data", 64'(o_dump_data), 64'd0);
    chk("mid_rst_addr", 64'({o_dbg_reg_addr, o_dbg_mem_addr}), 64'd0);
    chk("mid_rst_ctrl", 64'({o_cmd_ready, o_enable, o_halted, o_err, o_pipe_reset}), 64'b10000);
    chk("mid_rst_cnt", 64'(o_cycle_cnt), 64'd0);
    i_reset = 1'b1;
    i_dump_ready = 1'b0;
    @(negedge i_clk);
    send(2'b01);
    chk("post_rst_step", 64'(o_enable), 64'd1);
    @(negedge i_clk);
    chk("post_rst_idle", 64'({o_enable, o_cmd_ready}), 64'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
